trng_core: RTL
==============

TRNG_CORE -- requirements
Module: trng_core

Interface
REQ-001 Parameter N_RO, default 4: number of ring-oscillator entropy inputs, 1..16.
REQ-002 Parameter WIDTH, default 8: output word width in bits, 2..32.
REQ-003 Parameter DIV, default 4: clock cycles per sample strobe, 1..256.
REQ-004 Parameter RCT_LIMIT, default 32: repetition-count health limit, 2..255.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 en  input  1  collection enable.
REQ-008 ro_in  input  N_RO  asynchronous raw ring-oscillator outputs.
REQ-009 rnd_data  output  WIDTH  random word; valid only while rnd_valid=1.
REQ-010 rnd_valid  output  1  word available.
REQ-011 rnd_ready  input  1  consumer accepts the word.
REQ-012 health_fail  output  1  sticky repetition-count failure flag.

Function
REQ-013 Each ro_in bit SHALL pass through a 2-flop synchronizer; raw_bit = XOR of all synchronized bits.
REQ-014 div_cnt SHALL count 0..DIV-1 while en=1 and state=COLLECT; strobe asserts in the cycle div_cnt=DIV-1, after which div_cnt wraps to 0.
REQ-015 FSM states SHALL be IDLE, COLLECT, FULL, FAIL.
REQ-016 IDLE->COLLECT when en=1; COLLECT/FULL->IDLE when en=0; any state->FAIL on health failure.
REQ-017 On each strobe in COLLECT, the accepted bit SHALL shift in at the LSB of shreg (shift left), and bit_cnt SHALL increment.
REQ-018 When bit_cnt reaches WIDTH: if rnd_valid=0, or rnd_valid=1 and rnd_ready=1 in the same cycle, shreg SHALL load rnd_data, rnd_valid SHALL be 1 next cycle, and bit_cnt SHALL clear; otherwise state SHALL become FULL.
REQ-019 In FULL, div_cnt SHALL hold, no bits SHALL be sampled, and the pending load SHALL occur in the cycle rnd_valid=1 and rnd_ready=1; state then returns to COLLECT.
REQ-020 Handshake: rnd_valid SHALL stay 1 and rnd_data SHALL stay stable until a cycle with rnd_ready=1; rnd_valid SHALL drop the next cycle unless a new word loads simultaneously.
REQ-021 en=0 SHALL clear div_cnt, bit_cnt, shreg and VN pair state; rnd_data/rnd_valid SHALL be unaffected and can still be consumed.
REQ-022 Health: rct_cnt SHALL count consecutive equal raw_bit values at strobes (before debiasing), starting at 1 for a new value; when it reaches RCT_LIMIT, health_fail SHALL assert the next cycle.
REQ-023 In FAIL, no new word SHALL load; a word already in the output register remains consumable; exit is by rst only.
REQ-024 Sampling-to-first-effect latency: ro_in change SHALL be visible in raw_bit 2 cycles later.

Reset
REQ-025 rst=1 SHALL set state=IDLE, div_cnt=0, bit_cnt=0, shreg=0, rct_cnt=0, VN state cleared, rnd_data=0, rnd_valid=0, health_fail=0; rst overrides all other inputs, including mid-word and mid-handshake.

Configuration
REQ-026 Macro TRNG_VON_NEUMANN_EN SHALL select von Neumann debiasing.
REQ-027 With TRNG_VON_NEUMANN_EN defined: strobes SHALL pair raw bits; pair (0,1) emits 0, pair (1,0) emits 1, (0,0)/(1,1) are discarded; only emitted bits reach REQ-017.
REQ-028 Without TRNG_VON_NEUMANN_EN: every strobe's raw_bit is accepted directly; no pair state exists.

Verification (N_RO=4, WIDTH=8, DIV=4, RCT_LIMIT=32 unless noted)
REQ-029 Macro off, en=1, rnd_ready=1, raw_bit alternating 1,0 per strobe starting with 1 -> rnd_data=0xAA, rnd_valid pulses once per 32 cycles; health_fail stays 0.
REQ-030 All ro_in held 0, en=1 -> health_fail=1 the cycle after the 32nd strobe; no further rnd_valid after any pending word is consumed; only rst clears it.
REQ-031 Alternating pattern, rnd_ready=0 for 100 cycles -> rnd_valid=1 with rnd_data=0xAA held stable, state FULL, div_cnt frozen; ready=1 -> second 0xAA available the next cycle.
REQ-032 Macro on, raw pairs (0,1),(1,1),(1,0) repeated -> emitted bits 0,1,0,1,... ; rnd_data=0x55 after 8 emitted bits (24 strobes).
REQ-033 rst=1 pulsed after 5 bits collected with rnd_valid=1 -> next cycle all outputs 0, state IDLE; subsequent word is built from fresh bits only.
REQ-034 en dropped after 3 bits with rnd_valid=1 -> held word still consumable; re-enable restarts bit_cnt at 0.

Source files
------------

// File: rtl/trng_core.sv
// trng_core: ring-oscillator true random number generator core.
//
// Every ro_in bit passes through a two-flop synchronizer. raw_bit is the XOR
// of the synchronized bits. raw_bit is sampled once every DIV cycles while
// collecting. Accepted bits are shifted into a word register at the LSB. A
// completed word is handed out over a valid/ready pair. A repetition-count
// health test runs on the raw samples. Its failure is sticky and only rst
// clears it.
//
// Optional feature: define TRNG_VON_NEUMANN_EN to pair up the raw samples and
// apply von Neumann debiasing. Pair (0,1) emits 0, pair (1,0) emits 1, and
// equal pairs are dropped.
//
// Ports:
//   clk          clock, all state on rising edge
//   rst          synchronous active-high reset
//   en           collection enable
//   ro_in        asynchronous ring-oscillator outputs [N_RO]
//   rnd_data     random word [WIDTH], meaningful while rnd_valid=1
//   rnd_valid    word available
//   rnd_ready    consumer accepts the word
//   health_fail  sticky repetition-count failure flag
module trng_core #(
    parameter int unsigned N_RO      = 4,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DIV       = 4,
    parameter int unsigned RCT_LIMIT = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_RO-1:0]  ro_in,
    output logic [WIDTH-1:0] rnd_data,
    output logic             rnd_valid,
    input  logic             rnd_ready,
    output logic             health_fail
);

    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [7:0]       RCT_MAX  = 8'(RCT_LIMIT);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;
    localparam logic [1:0] ST_FAIL    = 2'd3;

    logic [N_RO-1:0]  sync1_q, sync2_q;
    logic             raw_bit;

    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [7:0]       rct_q, rct_d;
    logic             rct_last_q, rct_last_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             fail_q, fail_d;

    logic             strobe, consume, accept, acc_bit;
    logic             load, rct_trip;
    logic [7:0]       rct_next;
    logic [WIDTH-1:0] load_word;

`ifdef TRNG_VON_NEUMANN_EN
    logic             vn_have_q, vn_have_d;
    logic             vn_first_q, vn_first_d;
`endif

    // The synchronizers carry no reset. Their contents are only meaningful
    // once ro_in has been sampled for two cycles.
    always_ff @(posedge clk) begin
        sync1_q <= ro_in;
        sync2_q <= sync1_q;
    end

    assign raw_bit = ^sync2_q;

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        rct_d      = rct_q;
        rct_last_d = rct_last_q;
        data_d     = data_q;
        valid_d    = valid_q;
        fail_d     = fail_q;
        load       = 1'b0;
        load_word  = shreg_q;

        consume = valid_q & rnd_ready;
        strobe  = (state_q == ST_COLLECT) && en && (div_q == DIV_LAST);

        // rct_q == 0 means no previous sample exists (fresh after reset).
        rct_next = (rct_q != 8'd0 && raw_bit == rct_last_q) ? rct_q + 8'd1 : 8'd1;
        rct_trip = strobe && (rct_next >= RCT_MAX);
        if (strobe) begin
            rct_d      = rct_next;
            rct_last_d = raw_bit;
        end

`ifdef TRNG_VON_NEUMANN_EN
        vn_have_d  = vn_have_q;
        vn_first_d = vn_first_q;
        accept     = 1'b0;
        acc_bit    = vn_first_q;
        if (strobe) begin
            if (!vn_have_q) begin
                vn_have_d  = 1'b1;
                vn_first_d = raw_bit;
            end else begin
                vn_have_d = 1'b0;
                accept    = (vn_first_q != raw_bit);
            end
        end
`else
        accept  = strobe;
        acc_bit = raw_bit;
`endif

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (rct_trip) begin
                    // Health failure wins over a word completing on the same strobe.
                    state_d = ST_FAIL;
                    fail_d  = 1'b1;
                end else begin
                    div_d = strobe ? '0 : div_q + 1'b1;
                    if (accept) begin
                        shreg_d = {shreg_q[WIDTH-2:0], acc_bit};
                        if (bit_cnt_q == CNT_LAST) begin
                            if (!valid_q || consume) begin
                                load      = 1'b1;
                                load_word = shreg_d;
                                bit_cnt_d = '0;
                            end else begin
                                // Finished word waits in shreg until the output frees up.
                                state_d   = ST_FULL;
                                bit_cnt_d = CNT_FULL;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
            end
            ST_FULL: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (consume) begin
                    load      = 1'b1;
                    load_word = shreg_q;
                    bit_cnt_d = '0;
                    state_d   = ST_COLLECT;
                end
            end
            ST_FAIL: begin
            end
            default: begin
            end
        endcase

        // Disabling drops any partial or pending word. The output register
        // is left alone.
        if (!en) begin
            div_d     = '0;
            bit_cnt_d = '0;
            shreg_d   = '0;
`ifdef TRNG_VON_NEUMANN_EN
            vn_have_d  = 1'b0;
            vn_first_d = 1'b0;
`endif
        end

        if (load) begin
            data_d  = load_word;
            valid_d = 1'b1;
        end else if (consume) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            rct_q      <= '0;
            rct_last_q <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            rct_q      <= rct_d;
            rct_last_q <= rct_last_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            fail_q     <= fail_d;
        end
    end

`ifdef TRNG_VON_NEUMANN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            vn_have_q  <= 1'b0;
            vn_first_q <= 1'b0;
        end else begin
            vn_have_q  <= vn_have_d;
            vn_first_q <= vn_first_d;
        end
    end
`endif

    assign rnd_data    = data_q;
    assign rnd_valid   = valid_q;
    assign health_fail = fail_q;

endmodule
